// File: rtl/mem_bridge_pkg.sv
// Shared types and defaults for the memory bridge between the multicycle
// controller and an external request/acknowledge memory port.
package mem_bridge_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } bridge_state_t;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_bridge_wait_timer.sv
// Counts BUSY cycles spent waiting for an acknowledge and flags the cycle
// in which the count reaches LIMIT, so the bridge can leave BUSY on that edge.
module wait_timer
    import mem_bridge_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority so a fresh transaction always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is flagged in the waiting cycle whose increment lands on LIMIT.
    always_comb begin
        count   = count_q;
        expired = enable && (count_q == CNT_W'(LIMIT - 1));
    end

endmodule

// File: rtl/mem_bridge.sv
// Bridge from the controller's mem_read/mem_write strobes to a single
// outstanding external memory request. The controller stalls while a
// transfer is pending; results land in instr/old_pc (fetch) or data (load).
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            ir_write,
    input  logic [XLEN-1:0] adr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] pc,
    output logic            stall,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] data,
    output logic            err,
    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic            m_ack,
    input  logic [XLEN-1:0] m_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bridge_state_t state_q, state_d;

    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            irw_q, irw_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] old_pc_q, old_pc_d;
    logic [XLEN-1:0] data_q, data_d;

    logic             req_any;
    logic             accept;
    logic             complete_rd;
    logic             tmr_enable;
    logic             tmr_expired;
    logic [CNT_W-1:0] tmr_count;
    logic             unused_tmr_count;

    assign req_any          = mem_read | mem_write;
    assign accept           = (state_q == IDLE) && req_any && word_aligned(adr[1:0]);
    assign complete_rd      = (state_q == BUSY) && m_ack && !we_q;
    assign tmr_enable       = (state_q == BUSY) && !m_ack;
    // The running count is informational; only the expiry strobe steers the FSM.
    assign unused_tmr_count = ^tmr_count;

    wait_timer #(
        .LIMIT (TIMEOUT),
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (tmr_enable),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: misaligned requests fault without touching the bus,
    // and ERR is absorbing until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = word_aligned(adr[1:0]) ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (m_ack) begin
                    state_d = DONE;
                end else if (tmr_expired) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the bus is only driven in BUSY and reads as zero otherwise.
    always_comb begin
        stall   = 1'b0;
        m_req   = 1'b0;
        err     = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        unique case (state_q)
            IDLE: stall = req_any;
            BUSY: begin
                stall   = 1'b1;
                m_req   = 1'b1;
                m_we    = we_q;
                m_addr  = adr_q;
                m_wdata = wdata_q;
            end
            DONE: stall = 1'b0;
            ERR: begin
                stall = 1'b1;
                err   = 1'b1;
            end
            default: stall = 1'b0;
        endcase
    end

    // Request capture and result steering; a simultaneous read and write
    // becomes a write.
    always_comb begin
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        pc_d     = pc_q;
        irw_d    = irw_q;
        we_d     = we_q;
        instr_d  = instr_q;
        old_pc_d = old_pc_q;
        data_d   = data_q;
        if (accept) begin
            adr_d   = adr;
            wdata_d = wdata;
            pc_d    = pc;
            irw_d   = ir_write;
            we_d    = mem_write;
        end
        if (complete_rd) begin
            if (irw_q) begin
                instr_d  = m_rdata;
                old_pc_d = pc_q;
            end else begin
                data_d = m_rdata;
            end
        end
    end

    // Captured request fields are only observed in BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        adr_q   <= adr_d;
        wdata_q <= wdata_d;
        pc_q    <= pc_d;
        irw_q   <= irw_d;
        we_q    <= we_d;
    end

    // Architectural result registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q  <= '0;
            old_pc_q <= '0;
            data_q   <= '0;
        end else begin
            instr_q  <= instr_d;
            old_pc_q <= old_pc_d;
            data_q   <= data_d;
        end
    end

    assign instr  = instr_q;
    assign old_pc = old_pc_q;
    assign data   = data_q;

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter: XLEN, 32, datapath/address width.
REQ-002 Parameter: TIMEOUT, 15, maximum number of BUSY cycles allowed without m_ack.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 mem_read  input  1  controller requests a read (fetch or load).
REQ-006 mem_write  input  1  controller requests a store.
REQ-007 ir_write  input  1  read is an instruction fetch; the result goes to instr/old_pc.
REQ-008 adr  input  XLEN  byte address from the controller datapath.
REQ-009 wdata  input  XLEN  store data.
REQ-010 pc  input  XLEN  current PC, captured as old_pc on a fetch.
REQ-011 stall  output  1  controller holds its state while high.
REQ-012 instr  output  XLEN  instruction register.
REQ-013 old_pc  output  XLEN  PC of the instruction held in instr.
REQ-014 data  output  XLEN  load data register.
REQ-015 err  output  1  sticky fault flag (timeout or misaligned access).
REQ-016 m_req  output  1  external memory request.
REQ-017 m_we  output  1  external write enable.
REQ-018 m_addr  output  XLEN  external address.
REQ-019 m_wdata  output  XLEN  external write data.
REQ-020 m_ack  input  1  external completion; m_rdata is valid in the same cycle.
REQ-021 m_rdata  input  XLEN  external read data.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY, DONE and ERR.
REQ-023 IDLE: stall SHALL equal mem_read|mem_write (combinational); m_req=0.
REQ-024 IDLE with mem_read|mem_write: on the clock edge, capture adr, wdata, pc and ir_write, set we=mem_write, and go to BUSY; if mem_read and mem_write are both high, the write SHALL win.
REQ-025 IDLE with adr[1:0]!=0 on a request: go to ERR and never assert m_req.
REQ-026 BUSY: m_req=1, stall=1; m_addr, m_we and m_wdata SHALL be driven from the captured registers and stay stable until m_ack.
REQ-027 BUSY with m_ack and a read: load m_rdata into instr and old_pc (if ir_write was captured), otherwise into data; go to DONE.
REQ-028 BUSY with m_ack and a write: leave instr, old_pc and data unchanged; go to DONE.
REQ-029 DONE: stall=0 and m_req=0 for exactly one cycle; requests in DONE SHALL be ignored; then go to IDLE.
REQ-030 Minimum stall: 2 cycles (request cycle plus one BUSY cycle with m_ack); stall SHALL drop in the following cycle.
REQ-031 Timeout: the counter SHALL clear on entry to BUSY and increment each BUSY cycle without m_ack; when it reaches TIMEOUT, go to ERR.
REQ-032 ERR: err=1, stall=1, m_req=0; ERR SHALL be left only by reset.
REQ-033 m_ack outside BUSY SHALL be ignored.
REQ-034 m_addr, m_we and m_wdata SHALL be 0 whenever m_req=0.

Reset
REQ-035 Reset SHALL force state=IDLE, clear instr, old_pc, data, the counter and err, and drive m_req=0 immediately (asynchronously), including mid-transaction.
REQ-036 After reset deassertion, the first request SHALL be accepted with no extra latency.

Structure
REQ-037 The shared package SHALL hold the bridge_state_t enum, the XLEN default and the TIMEOUT default.
REQ-038 The timeout counter SHALL be a sub-module wait_timer (ports: clear, enable, count, expired).
REQ-039 All registers SHALL be plain flops; no memories are inferred.

Verification
REQ-040 Fetch with adr=0x10, pc=0x10, ir_write=1, m_ack on the first BUSY cycle with m_rdata=0x00500113 -> stall high for 2 cycles; instr=0x00500113, old_pc=0x10.
REQ-041 Load with adr=0x24, m_ack after 3 BUSY cycles with m_rdata=0xDEADBEEF -> data=0xDEADBEEF; stall high for 4 cycles; instr unchanged.
REQ-042 Store with adr=0x8, wdata=0x55 -> m_req=1, m_we=1, m_addr=0x8, m_wdata=0x55 held until m_ack; data unchanged.
REQ-043 No m_ack with TIMEOUT=15 -> err=1 after 15 BUSY cycles; m_req=0; stall stays high until reset.
REQ-044 Misaligned read at adr=0x6 -> m_req never asserted; err=1 on the next cycle.
REQ-045 Reset asserted on BUSY cycle 2 -> m_req=0 at once; all outputs are 0; a new fetch after reset completes normally.
